// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - decodes a scanned active-low 7-segment bus back into 4-digit hex frames
module seg7_scan_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  d_sel,
    input  logic [7:0]  d_out,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  dp,
    output logic [3:0]  seg_err,
    output logic        frame_valid,
    output logic        sel_err,
    output logic        stale
);
    localparam logic [7:0]  SETTLE_N  = 8'(SETTLE_CYCLES);
    localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT_CYCLES);
    localparam logic [3:0]  SEL_IDLE  = 4'b1111;

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;
    state_t state, state_nx;

    logic [3:0]  sel_q, lat_sel, lat_sel_nx, bad_sel;
    logic [7:0]  seg_q, lat_seg, lat_seg_nx;
    logic [7:0]  cnt, cnt_nx, bad_cnt, bad_cnt_nx;
    logic [15:0] to_cnt;
    logic [3:0]  seen, seen_nx;
    logic [15:0] sh_val;
    logic [3:0]  sh_blank, sh_dp, sh_err;
    logic        sel_onehot, sel_bad, same, capture, to_hit, wait_eval;
    logic [3:0]  dec_val;
    logic        dec_blank, dec_err;

    assign sel_onehot = (sel_q == 4'b1110) || (sel_q == 4'b1101) ||
                        (sel_q == 4'b1011) || (sel_q == 4'b0111);
    assign sel_bad    = !sel_onehot && (sel_q != SEL_IDLE);
    assign same       = (sel_q == lat_sel) && (seg_q == lat_seg);
    assign to_hit     = !capture && (to_cnt == TIMEOUT_N - 16'd1);

    always_comb begin
        state_nx   = state;
        lat_sel_nx = lat_sel;
        lat_seg_nx = lat_seg;
        cnt_nx     = cnt;
        capture    = 1'b0;
        wait_eval  = 1'b0;
        case (state)
            S_SETTLE: begin
                if (cnt == SETTLE_N) begin
                    capture  = 1'b1;
                    state_nx = S_HOLD;
                end else if (!sel_onehot) begin
                    // idle or malformed select abandons the digit being settled
                    state_nx = S_WAIT;
                end else if (same) begin
                    cnt_nx = cnt + 8'd1;
                end else begin
                    lat_sel_nx = sel_q;
                    lat_seg_nx = seg_q;
                    cnt_nx     = 8'd1;
                end
            end
            S_HOLD:  wait_eval = !same;
            default: wait_eval = 1'b1;
        endcase
        if (wait_eval) begin
            if (sel_onehot) begin
                state_nx   = S_SETTLE;
                lat_sel_nx = sel_q;
                lat_seg_nx = seg_q;
                cnt_nx     = 8'd1;
            end else begin
                state_nx = S_WAIT;
            end
        end
    end

    always_comb begin
        dec_val   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (lat_seg[7:1])
            7'b0000001: dec_val = 4'h0;
            7'b1001111: dec_val = 4'h1;
            7'b0010010: dec_val = 4'h2;
            7'b0000110: dec_val = 4'h3;
            7'b1001100: dec_val = 4'h4;
            7'b0100100: dec_val = 4'h5;
            7'b0100000: dec_val = 4'h6;
            7'b0001111: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0000100: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err = 1'b1;
        endcase
    end

    always_comb begin
        bad_cnt_nx = 8'd0;
        if (sel_bad) begin
            if ((sel_q == bad_sel) && (bad_cnt != 8'd0))
                bad_cnt_nx = (bad_cnt == 8'hFF) ? bad_cnt : bad_cnt + 8'd1;
            else
                bad_cnt_nx = 8'd1;
        end
    end

    // a capture in the completion cycle already belongs to the next frame
    always_comb begin
        seen_nx = (seen == 4'b1111) ? 4'b0000 : seen;
        if (capture)
            seen_nx = seen_nx | ~lat_sel;
        if (to_hit)
            seen_nx = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= SEL_IDLE;
            seg_q       <= 8'hFF;
            state       <= S_WAIT;
            lat_sel     <= SEL_IDLE;
            lat_seg     <= 8'hFF;
            cnt         <= 8'd0;
            bad_sel     <= SEL_IDLE;
            bad_cnt     <= 8'd0;
            to_cnt      <= 16'd0;
            seen        <= 4'b0000;
            sh_val      <= 16'h0000;
            sh_blank    <= 4'b0000;
            sh_dp       <= 4'b0000;
            sh_err      <= 4'b0000;
            digits      <= 16'h0000;
            blank       <= 4'b0000;
            dp          <= 4'b0000;
            seg_err     <= 4'b0000;
            frame_valid <= 1'b0;
            sel_err     <= 1'b0;
            stale       <= 1'b0;
        end else begin
            sel_q   <= d_sel;
            seg_q   <= d_out;
            state   <= state_nx;
            lat_sel <= lat_sel_nx;
            lat_seg <= lat_seg_nx;
            cnt     <= cnt_nx;
            bad_cnt <= bad_cnt_nx;
            if (sel_bad)
                bad_sel <= sel_q;
            if (bad_cnt_nx >= SETTLE_N)
                sel_err <= 1'b1;
            if (capture)
                to_cnt <= 16'd0;
            else if (to_cnt != TIMEOUT_N)
                to_cnt <= to_cnt + 16'd1;
            for (int i = 0; i < 4; i++) begin
                if (capture && !lat_sel[i]) begin
                    sh_val[4*i +: 4] <= dec_val;
                    sh_blank[i]      <= dec_blank;
                    sh_dp[i]         <= ~lat_seg[0];
                    sh_err[i]        <= dec_err;
                end
            end
            seen        <= seen_nx;
            frame_valid <= (seen == 4'b1111);
            if (seen == 4'b1111) begin
                digits  <= sh_val;
                blank   <= sh_blank;
                dp      <= sh_dp;
                seg_err <= sh_err;
                stale   <= 1'b0;
            end
            if (to_hit)
                stale <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - directed checks of the 7-segment scan capture block
module tb_seg7_scan_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  d_sel;
    logic [7:0]  d_out;
    logic [15:0] digits;
    logic [3:0]  blank, dp, seg_err;
    logic        frame_valid, sel_err, stale;

    int n_tests  = 0;
    int n_fail   = 0;
    int fv_total = 0;
    int fv0;

    always #5 clk = ~clk;

    seg7_scan_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .d_sel(d_sel), .d_out(d_out),
        .digits(digits), .blank(blank), .dp(dp), .seg_err(seg_err),
        .frame_valid(frame_valid), .sel_err(sel_err), .stale(stale)
    );

    always @(negedge clk) begin
        if (frame_valid === 1'b1)
            fv_total = fv_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic show(input logic [3:0] s, input logic [7:0] g, input int n);
        d_sel = s;
        d_out = g;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        show(4'b1111, 8'hFF, n);
    endtask

    task automatic scan4(input logic [7:0] g0, input logic [7:0] g1,
                         input logic [7:0] g2, input logic [7:0] g3);
        show(4'b1110, g0, 8);
        show(4'b1101, g1, 8);
        show(4'b1011, g2, 8);
        show(4'b0111, g3, 8);
        idle(4);
    endtask

    initial begin
        d_sel = 4'b1111;
        d_out = 8'hFF;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_blank", 32'(blank), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_seg_err", 32'(seg_err), 32'h0);
        chk("rst_frame_valid", 32'(frame_valid), 32'h0);
        chk("rst_sel_err", 32'(sel_err), 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);

        // 3, 0, blank, blank
        fv0 = fv_total;
        scan4(8'h0D, 8'h03, 8'hFF, 8'hFF);
        @(negedge clk);
        chk("scan_fv", 32'(fv_total - fv0), 32'd1);
        chk("scan_digits", 32'(digits), 32'h0003);
        chk("scan_blank", 32'(blank), 32'b1100);
        chk("scan_seg_err", 32'(seg_err), 32'h0);
        chk("scan_dp", 32'(dp), 32'h0);

        // digit 0 last: 2-cycle glitch showing 8, then stable 5; digit 3 F with dp
        fv0 = fv_total;
        show(4'b1101, 8'h9F, 8);
        show(4'b1011, 8'h11, 8);
        show(4'b0111, 8'h70, 8);
        show(4'b1110, 8'h01, 2);
        show(4'b1110, 8'h49, 8);
        idle(4);
        chk("glitch_fv", 32'(fv_total - fv0), 32'd1);
        chk("glitch_digits", 32'(digits), 32'hFA15);
        chk("glitch_dp", 32'(dp), 32'b1000);
        chk("glitch_blank", 32'(blank), 32'h0);

        // 7, 9, 1010101 (invalid), 2
        fv0 = fv_total;
        scan4(8'h1F, 8'h09, 8'hAB, 8'h25);
        chk("segerr_fv", 32'(fv_total - fv0), 32'd1);
        chk("segerr_digits", 32'(digits), 32'h2097);
        chk("segerr_seg_err", 32'(seg_err), 32'b0100);
        chk("segerr_blank", 32'(blank), 32'h0);

        chk("selerr_before", 32'(sel_err), 32'h0);
        fv0 = fv_total;
        show(4'b0011, 8'h01, 6);
        @(negedge clk);
        chk("selerr_set", 32'(sel_err), 32'h1);
        idle(20);
        chk("selerr_sticky", 32'(sel_err), 32'h1);
        chk("selerr_no_fv", 32'(fv_total - fv0), 32'd0);
        chk("selerr_digits", 32'(digits), 32'h2097);

        // three digits then silence; last capture lands on edge 6 of the third window
        fv0 = fv_total;
        show(4'b1110, 8'h9F, 8);
        show(4'b1101, 8'h25, 8);
        show(4'b1011, 8'h0D, 8);
        d_sel = 4'b1111;
        d_out = 8'hFF;
        repeat (97) @(posedge clk);
        @(negedge clk);
        chk("timeout_stale_early", 32'(stale), 32'h0);
        @(negedge clk);
        chk("timeout_stale", 32'(stale), 32'h1);
        chk("timeout_digits", 32'(digits), 32'h2097);
        chk("timeout_no_fv", 32'(fv_total - fv0), 32'd0);
        show(4'b0111, 8'h1F, 8);
        idle(4);
        chk("timeout_seen_cleared", 32'(fv_total - fv0), 32'd0);
        chk("timeout_stale_held", 32'(stale), 32'h1);
        show(4'b0111, 8'hC1, 8);
        show(4'b1110, 8'h01, 8);
        show(4'b1101, 8'h09, 8);
        show(4'b1011, 8'h11, 8);
        idle(4);
        chk("timeout_rescan_fv", 32'(fv_total - fv0), 32'd1);
        chk("timeout_rescan_digits", 32'(digits), 32'hBA98);
        chk("timeout_rescan_stale", 32'(stale), 32'h0);

        // reset after two captures
        show(4'b1110, 8'h0D, 8);
        show(4'b1101, 8'h03, 8);
        d_sel = 4'b1111;
        d_out = 8'hFF;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_digits", 32'(digits), 32'h0);
        chk("midrst_blank", 32'(blank), 32'h0);
        chk("midrst_dp", 32'(dp), 32'h0);
        chk("midrst_seg_err", 32'(seg_err), 32'h0);
        chk("midrst_sel_err", 32'(sel_err), 32'h0);
        chk("midrst_stale", 32'(stale), 32'h0);
        fv0 = fv_total;
        show(4'b1011, 8'h49, 8);
        show(4'b0111, 8'h49, 8);
        idle(4);
        chk("midrst_partial_no_fv", 32'(fv_total - fv0), 32'd0);
        show(4'b1011, 8'h0D, 8);
        show(4'b0111, 8'h99, 8);
        show(4'b1110, 8'h9F, 8);
        show(4'b1101, 8'h25, 8);
        idle(4);
        chk("midrst_full_fv", 32'(fv_total - fv0), 32'd1);
        chk("midrst_full_digits", 32'(digits), 32'h4321);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receiving end of the multiplexed 7-segment display interface (d_sel/d_out) that the display scanner drives.
- Samples the scanned select and segment lines and decodes each segment pattern back to a 4-bit hex value per digit.
- Publishes one coherent 4-digit frame at a time, with blank, decimal-point and error flags.
- Used in self-check benches and for on-board loopback of the timer display path.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical samples (same select, same segments) required before a digit is captured; legal range 1..255.
- TIMEOUT_CYCLES, 65535, cycles without any capture before the partial frame is discarded and stale asserts; 16-bit counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- d_sel  input  4  digit select, active-low one-hot; 4'b1111 = no digit.
- d_out  input  8  segments, active-low; bit7..bit1 = a..g, bit0 = dp.
- digits  output  16  captured hex values; digit n at [4n+3:4n].
- blank  output  4  digit n pattern was all segments off.
- dp  output  4  digit n decimal point lit.
- seg_err  output  4  digit n pattern not in decode table.
- frame_valid  output  1  one-cycle pulse when digits/blank/dp/seg_err update.
- sel_err  output  1  sticky; d_sel held a non-one-hot, non-idle value for SETTLE_CYCLES samples.
- stale  output  1  timeout occurred; cleared on the next frame_valid.

Behaviour:
- Reset: every output is 0; shadow registers, seen mask, settle and timeout counters clear; FSM enters S_WAIT.
- Inputs pass through one register stage. All timing below is measured from the registered values.
- Decode (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - 1111111 = blank, value 0.
  - Any other pattern: seg_err bit set, value 0.
  - dp = ~d_out[0].
- S_WAIT:
  - If d_sel is one-hot: go to S_SETTLE, load settle count = 1, latch sel/seg.
  - If d_sel is neither 4'b1111 nor one-hot: count toward sel_err.
- S_SETTLE:
  - Sample equal to the latched sel/seg: increment count.
  - Sample differs: reload the latch, count = 1.
  - d_sel = 4'b1111: return to S_WAIT.
  - When count reaches SETTLE_CYCLES, next cycle: write the decoded digit into the shadow slot for the selected digit, set its seen bit, go to S_HOLD.
- S_HOLD:
  - Stays while the sample is unchanged; no recapture.
  - Any change in sel or seg: back to S_WAIT evaluation in the same cycle.
- Recapture of an already-seen digit before the frame completes overwrites its shadow slot (latest value wins).
- Frame completion: the cycle after the seen mask becomes 4'b1111:
  - Copy shadow to digits/blank/dp/seg_err.
  - Pulse frame_valid for 1 cycle.
  - Clear seen mask and stale.
  - Outputs otherwise hold between frames.
- Timeout counter:
  - Resets on every capture; saturates.
  - On reaching TIMEOUT_CYCLES: clear seen mask, set stale. Outputs keep the last frame.
- sel_err is sticky until rst.
- Minimum latency from a stable digit to its capture: 1 (input register) + SETTLE_CYCLES + 1 cycles.

Test Plan:
- Reset mid-frame, after 2 digits captured -> all outputs 0, no frame_valid until 4 new digits are captured.
- Scan d_sel 1110,1101,1011,0111 with patterns 3,0,blank,blank, 8 cycles each, SETTLE_CYCLES=4 -> one frame_valid; digits=16'h0003, blank=4'b1100, seg_err=0.
- Digit 0 segment glitch lasting 2 cycles (< SETTLE_CYCLES), then stable 5 -> digit0 captured as 5, never as the glitch value.
- Pattern 1010101 on digit 2 -> seg_err=4'b0100, digits[11:8]=0; remaining digits decode normally.
- d_sel=4'b0011 held 6 cycles -> sel_err=1 and stays 1; no capture occurs.
- Scanning stops after 3 digits, TIMEOUT_CYCLES=100 -> stale=1 at cycle 100 after the last capture, outputs unchanged; a full 4-digit scan afterwards gives frame_valid and stale=0.
